// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides: operand register, then result/flag register.
// Define ALU_PIPE_FLAGS_EN to build carry/overflow flags for ADD/SUB; otherwise they are tied to 0.
module alu_pipe #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NB_DATA-1:0] dato_a,
  input  logic [NB_DATA-1:0] dato_b,
  input  logic [NB_OP-1:0]   opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NB_DATA-1:0] out,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               flag_ovf,
  output logic               err
);

  localparam int NB_SH = $clog2(NB_DATA);

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

  logic [NB_DATA-1:0] s1_a, s1_b;
  logic [NB_OP-1:0]   s1_op;
  logic               s1_valid, s2_valid;
  logic               s1_adv;

  logic [NB_DATA-1:0] out_q;
  logic               zero_q, carry_q, ovf_q, err_q;

  logic [NB_DATA-1:0] res;
  logic               res_carry, res_ovf, res_err;
  logic [NB_SH-1:0]   shamt;

  // Stage 2 can take a new op when it is empty or its result leaves this cycle.
  assign s1_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign shamt    = s1_b[NB_SH-1:0];

`ifdef ALU_PIPE_FLAGS_EN
  logic [NB_DATA:0] sum_ext, diff_ext;
  assign sum_ext  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff_ext = {1'b0, s1_a} - {1'b0, s1_b};
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    case (s1_op)
`ifdef ALU_PIPE_FLAGS_EN
      OP_ADD: begin
        res       = sum_ext[NB_DATA-1:0];
        res_carry = sum_ext[NB_DATA];
        res_ovf   = (s1_a[NB_DATA-1] == s1_b[NB_DATA-1]) &&
                    (sum_ext[NB_DATA-1] != s1_a[NB_DATA-1]);
      end
      OP_SUB: begin
        res       = diff_ext[NB_DATA-1:0];
        res_carry = diff_ext[NB_DATA];
        res_ovf   = (s1_a[NB_DATA-1] != s1_b[NB_DATA-1]) &&
                    (diff_ext[NB_DATA-1] != s1_a[NB_DATA-1]);
      end
`else
      OP_ADD: res = s1_a + s1_b;
      OP_SUB: res = s1_a - s1_b;
`endif
      OP_AND: res = s1_a & s1_b;
      OP_OR:  res = s1_a | s1_b;
      OP_XOR: res = s1_a ^ s1_b;
      OP_NOR: res = ~(s1_a | s1_b);
      OP_SRA: res = $unsigned($signed(s1_a) >>> shamt);
      OP_SRL: res = s1_a >> shamt;
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s2_valid <= 1'b0;
      out_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a  <= dato_a;
          s1_b  <= dato_b;
          s1_op <= opcode;
        end
      end
      // Result registers only change on a load, so a stalled result stays stable.
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_q   <= res;
          zero_q  <= (res == '0);
          carry_q <= res_carry;
          ovf_q   <= res_ovf;
          err_q   <= res_err;
        end
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out        = out_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: arithmetic reference model plus scoreboard, and directed literal vectors.
module tb_alu_pipe;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NB-1:0] dato_a = '0;
  logic [NB-1:0] dato_b = '0;
  logic [5:0]    opcode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NB-1:0] out;
  logic          flag_zero, flag_carry, flag_ovf, err;

  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int popped = 0;
  int cyc = 0;

  typedef struct packed {
    logic [NB-1:0] out;
    logic          zero;
    logic          carry;
    logic          ovf;
    logic          err;
  } res_t;

  res_t exp_q[$];

  alu_pipe #(.NB_DATA(NB), .NB_OP(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dato_a(dato_a), .dato_b(dato_b), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .flag_ovf(flag_ovf), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, results reduced modulo 2**NB.
  function automatic res_t model(input logic [5:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b);
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int sh = ub % NB;
    int r = 0;
    res_t m;
    m = '0;
    case (op)
      6'b100000: begin
        r = ua + ub;
        m.carry = (r > 255);
        m.ovf = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      6'b100010: begin
        r = ua - ub;
        m.carry = (ua < ub);
        m.ovf = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      6'b100100: r = ua & ub;
      6'b100101: r = ua | ub;
      6'b100110: r = ua ^ ub;
      6'b100111: r = ~(ua | ub);
      6'b000011: r = sa >>> sh;
      6'b000010: r = ua >> sh;
      default: begin
        r = 0;
        m.err = 1'b1;
      end
    endcase
    m.out = r[NB-1:0];
    m.zero = (m.out == '0);
`ifndef ALU_PIPE_FLAGS_EN
    m.carry = 1'b0;
    m.ovf = 1'b0;
`endif
    return m;
  endfunction

  // Scoreboard: handshakes are decided by the values seen half a cycle before the rising edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          check("sb_out", out, exp_q[0].out);
          check("sb_zero", flag_zero, exp_q[0].zero);
          check("sb_carry", flag_carry, exp_q[0].carry);
          check("sb_ovf", flag_ovf, exp_q[0].ovf);
          check("sb_err", err, exp_q[0].err);
          if (out_ready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(opcode, dato_a, dato_b));
        pushed++;
      end
    end
  end

  // Single op into an empty pipe with out_ready=1; checks latency and literal results.
  task automatic op_test(input string name, input logic [5:0] op, input logic [NB-1:0] a,
                         input logic [NB-1:0] b, input logic [NB-1:0] e_out, input logic e_zero,
                         input logic e_err, input logic e_c, input logic e_v);
    opcode = op; dato_a = a; dato_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check({name, "_not_yet_valid"}, out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_out"}, out, e_out);
    check({name, "_zero"}, flag_zero, e_zero);
    check({name, "_err"}, err, e_err);
`ifdef ALU_PIPE_FLAGS_EN
    check({name, "_carry"}, flag_carry, e_c);
    check({name, "_ovf"}, flag_ovf, e_v);
`else
    check({name, "_carry"}, flag_carry, 1'b0);
    check({name, "_ovf"}, flag_ovf, 1'b0);
    if (e_c || e_v) ;
`endif
    @(posedge clk); #1;
  endtask

  // Offer one op and wait (bounded) for it to be accepted; returns at edge+1.
  task automatic send(input logic [5:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b);
    opcode = op; dato_a = a; dato_b = b; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1 in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("send_timeout_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int t0, p0, q0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 0);
    check("rst_zero", flag_zero, 1'b0);
    check("rst_carry", flag_carry, 1'b0);
    check("rst_ovf", flag_ovf, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1'b1);
    @(posedge clk); #1;

    op_test("add", 6'b100000, 8'd8, 8'd2, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    op_test("sub", 6'b100010, 8'd8, 8'd2, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    op_test("and", 6'b100100, 8'd8, 8'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    op_test("or", 6'b100101, 8'd3, 8'd1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    op_test("xor", 6'b100110, 8'd3, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    op_test("nor", 6'b100111, 8'd3, 8'd1, 8'd252, 1'b0, 1'b0, 1'b0, 1'b0);
    op_test("sra", 6'b000011, 8'h83, 8'h01, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
    op_test("srl", 6'b000010, 8'h83, 8'h01, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    op_test("sra_b9", 6'b000011, 8'h83, 8'h09, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
    op_test("srl_b9", 6'b000010, 8'h83, 8'h09, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    op_test("add_ovf", 6'b100000, 8'd127, 8'd1, 8'd128, 1'b0, 1'b0, 1'b0, 1'b1);
    op_test("add_carry", 6'b100000, 8'd255, 8'd1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    op_test("sub_borrow", 6'b100010, 8'd2, 8'd8, 8'd250, 1'b0, 1'b0, 1'b1, 1'b0);
    op_test("illegal", 6'b000000, 8'd5, 8'd7, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Full throughput: four accepts in four edges with out_ready held high.
    t0 = cyc; q0 = popped;
    send(6'b100000, 8'd10, 8'd20);
    send(6'b100111, 8'h0F, 8'hF0);
    send(6'b000011, 8'h80, 8'h07);
    send(6'b101010, 8'd1, 8'd1);
    check("throughput_cycles", cyc - t0, 4);
    drain();
    check("throughput_outputs", popped - q0, 4);

    // Backpressure: two ops fill the pipe, the third must wait; head result stays put.
    out_ready = 1'b0;
    p0 = pushed; q0 = popped;
    send(6'b100000, 8'd1, 8'd1);
    send(6'b100010, 8'd9, 8'd4);
    opcode = 6'b100110; dato_a = 8'hF0; dato_b = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_stable", out, 8'd2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(6'b100110, 8'hF0, 8'hFF);
    send(6'b000010, 8'h80, 8'h03);
    drain();
    check("bp_accepts", pushed - p0, 4);
    check("bp_outputs", popped - q0, 4);

    // Reset with two ops held in flight.
    out_ready = 1'b0;
    send(6'b100000, 8'd3, 8'd4);
    send(6'b100101, 8'd5, 8'd8);
    @(negedge clk);
    check("pre_reset_full", in_ready, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out", out, 0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_err", err, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_ghost_after_reset", out_valid, 1'b0);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
